// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the two-port external-SRAM arbiter.
// Size codes match the SRAM controller's rd_ctrl/wr_ctrl encoding.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    localparam logic [1:0] MEM_IDLE = 2'b00;

    localparam logic [2:0] RD_B  = 3'd1;
    localparam logic [2:0] RD_H  = 3'd2;
    localparam logic [2:0] RD_W  = 3'd3;
    localparam logic [2:0] RD_BU = 3'd4;
    localparam logic [2:0] RD_HU = 3'd5;
    localparam logic [2:0] RD_D  = 3'd6;

    localparam logic [2:0] WR_B  = 3'd1;
    localparam logic [2:0] WR_H  = 3'd2;
    localparam logic [2:0] WR_W  = 3'd3;
    localparam logic [2:0] WR_D  = 3'd4;

endpackage

// File: rtl/sram_arbiter_pick.sv
// Owner selection between fetch (I) and data (D) requesters.
// D wins ties until it has been granted MAX_D_STREAK times in a row over a waiting I.
module mem_arb_pick
#(
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_ireq,
    input  logic i_dreq,
    output logic o_sel_i,
    output logic o_sel_d
);

    localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);

    logic [SW-1:0] r_streak;
    logic          w_sat;

    assign w_sat = (r_streak == SW'(MAX_D_STREAK));

    always_comb begin
        o_sel_i = 1'b0;
        o_sel_d = 1'b0;
        if (i_en) begin
            if (i_dreq && !(i_ireq && w_sat)) begin
                o_sel_d = 1'b1;
            end else if (i_ireq) begin
                o_sel_i = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_streak <= '0;
        end else if (o_sel_i) begin
            r_streak <= '0;
        end else if (o_sel_d && i_ireq && !w_sat) begin
            r_streak <= r_streak + SW'(1);
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Serialises I-fetch and D-memory requests onto the single SRAM controller,
// holding each command until accepted and returning one response per grant.
module sram_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_D_STREAK = 4,
    parameter int unsigned TIMEOUT      = 64,
    parameter int unsigned ADDR_W       = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [2:0]        i_rd_ctrl,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [63:0]       i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [2:0]        d_rd_ctrl,
    input  logic [2:0]        d_wr_ctrl,
    input  logic [63:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [63:0]       d_rdata,
    output logic              d_err,
    output logic [2:0]        mem_rd_ctrl,
    output logic [2:0]        mem_wr_ctrl,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_din,
    input  logic [63:0]       mem_dout,
    input  logic [1:0]        mem_state,
    output logic              busy
);

    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    arb_state_t        r_state;
    arb_state_t        w_next;
    owner_t            r_owner;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_rd;
    logic [2:0]        r_wr;
    logic [63:0]       r_wdata;
    logic [63:0]       r_rdata;
    logic              r_err;
    logic [TW-1:0]     r_timer;

    logic              w_pick_en;
    logic              w_sel_i;
    logic              w_sel_d;
    logic              w_grant;
    logic              w_zero_ctrl;
    logic              w_timeout;
    logic              w_resp;
    logic [ADDR_W-1:0] w_lat_addr;
    logic [2:0]        w_lat_rd;
    logic [2:0]        w_lat_wr;
    logic [63:0]       w_lat_wdata;

    // Gating with rst keeps gnt low while reset holds the FSM in IDLE.
    assign w_pick_en = (r_state == IDLE) && !rst;

    mem_arb_pick #(
        .MAX_D_STREAK(MAX_D_STREAK)
    ) u_pick (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_pick_en),
        .i_ireq (i_req),
        .i_dreq (d_req),
        .o_sel_i(w_sel_i),
        .o_sel_d(w_sel_d)
    );

    assign w_grant = w_sel_i | w_sel_d;

    // Writes take priority: a D request with both ctrls set never reads.
    always_comb begin
        w_lat_addr  = i_addr;
        w_lat_rd    = i_rd_ctrl;
        w_lat_wr    = '0;
        w_lat_wdata = '0;
        if (w_sel_d) begin
            w_lat_addr  = d_addr;
            w_lat_wr    = d_wr_ctrl;
            w_lat_rd    = (d_wr_ctrl != '0) ? '0 : d_rd_ctrl;
            w_lat_wdata = d_wdata;
        end
    end

    assign w_zero_ctrl = (w_lat_rd == '0) && (w_lat_wr == '0);
    assign w_timeout   = (r_timer == TW'(TIMEOUT - 1));

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_grant) w_next = w_zero_ctrl ? RESP : ISSUE;
            end
            ISSUE: begin
                if (w_timeout)                  w_next = RESP;
                else if (mem_state != MEM_IDLE) w_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (w_timeout || mem_state == MEM_IDLE) w_next = RESP;
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= OWN_I;
            r_addr  <= '0;
            r_rd    <= '0;
            r_wr    <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_timer <= '0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_owner <= w_sel_d ? OWN_D : OWN_I;
                        r_addr  <= w_lat_addr;
                        r_rd    <= w_lat_rd;
                        r_wr    <= w_lat_wr;
                        r_wdata <= w_lat_wdata;
                        r_rdata <= '0;
                        r_err   <= w_zero_ctrl;
                        r_timer <= '0;
                    end
                end
                ISSUE, WAIT_DONE: begin
                    r_timer <= r_timer + TW'(1);
                    if (w_timeout) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end else if (r_state == WAIT_DONE && mem_state == MEM_IDLE) begin
                        r_rdata <= (r_wr != '0) ? '0 : mem_dout;
                        r_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_resp   = (r_state == RESP);
    assign i_gnt    = w_sel_i;
    assign d_gnt    = w_sel_d;
    assign i_rvalid = w_resp && (r_owner == OWN_I);
    assign d_rvalid = w_resp && (r_owner == OWN_D);
    assign i_rdata  = i_rvalid ? r_rdata : '0;
    assign d_rdata  = d_rvalid ? r_rdata : '0;
    assign i_err    = i_rvalid & r_err;
    assign d_err    = d_rvalid & r_err;

    assign mem_rd_ctrl = (r_state == ISSUE) ? r_rd : '0;
    assign mem_wr_ctrl = (r_state == ISSUE) ? r_wr : '0;
    assign mem_addr    = r_addr;
    assign mem_din     = r_wdata;
    assign busy        = (r_state != IDLE);

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single external-SRAM controller between two requesters: instruction fetch (I port, read-only) and data memory (D port, read/write).
- Sits between the core's fetch/LSU stages and the SRAM controller's rd_ctrl/wr_ctrl/addr/din/dout/state interface.
- Serialises requests and holds controller commands until the controller accepts them.
- Returns one response pulse per request, with a timeout error path.

Parameters:
- MAX_D_STREAK, 4: consecutive D grants allowed while I is pending, before I is forced.
- TIMEOUT, 64: cycles allowed in ISSUE+WAIT_DONE before an error response.
- ADDR_W, 64: address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- i_req  in  1  fetch request, held until i_gnt
- i_addr  in  ADDR_W  fetch address
- i_rd_ctrl  in  3  read size code (1..6)
- i_gnt  out  1  request latched (1-cycle pulse)
- i_rvalid  out  1  response valid (1-cycle pulse)
- i_rdata  out  64  read data
- i_err  out  1  error, qualified by i_rvalid
- d_req  in  1  data request, held until d_gnt
- d_addr  in  ADDR_W  data address
- d_rd_ctrl  in  3  read size code
- d_wr_ctrl  in  3  write size code (1..4); nonzero means write
- d_wdata  in  64  write data
- d_gnt  out  1  request latched
- d_rvalid  out  1  response valid (reads and writes)
- d_rdata  out  64  read data (0 for writes)
- d_err  out  1  error, qualified by d_rvalid
- mem_rd_ctrl  out  3  to controller
- mem_wr_ctrl  out  3  to controller
- mem_addr  out  ADDR_W  to controller
- mem_din  out  64  to controller
- mem_dout  in  64  from controller
- mem_state  in  2  controller state; 0 = idle
- busy  out  1  arbiter not in IDLE

Behaviour:
- Reset: rst asynchronous, active-high; clock clk. All outputs 0; state IDLE; streak 0; timer 0; latched request registers 0.
- States: IDLE, ISSUE, WAIT_DONE, RESP.
- IDLE:
  - If any request is pending, pick an owner, latch its addr/ctrl/wdata, and pulse that port's gnt in the same cycle. Go to ISSUE next cycle.
  - Exception: latched ctrl is all zero. Then go directly to RESP with err=1.
- Pick rule:
  - D only -> D. I only -> I.
  - Both -> D, unless streak == MAX_D_STREAK, in which case I.
  - Streak increments (saturating) when D is granted while i_req=1. Streak clears when I is granted.
- D write priority: if both d_wr_ctrl and d_rd_ctrl are nonzero, the request is a write; mem_rd_ctrl is driven 0.
- ISSUE:
  - Drive mem_* from latched registers; hold them every cycle until mem_state != 0.
  - When mem_state != 0, go to WAIT_DONE; mem ctrl outputs are 0 from the next cycle on.
- WAIT_DONE:
  - mem ctrl = 0. When mem_state == 0, capture mem_dout into the response register (reads only; writes capture 0) and go to RESP.
- RESP:
  - One cycle: owner's rvalid=1, rdata=captured, err per path. Then IDLE.
  - The next grant is possible in the cycle after RESP.
- Minimum latency for a grant at cycle 0 with the controller accepting immediately: ISSUE at cycle 1, WAIT_DONE at cycle 2. The controller read/write length adds cycles. RESP comes one cycle after mem_state returns to 0.
- Timer:
  - Cleared on entry to ISSUE; increments in ISSUE and WAIT_DONE.
  - On reaching TIMEOUT-1: go to RESP with err=1, rdata=0, mem ctrl forced 0.
- Non-owner port: gnt/rvalid stay 0. Its request stays pending and is not dropped.
- Requester-side changes on i_*/d_* inputs after gnt are ignored.
- Reset mid-operation: immediate IDLE, no response is issued, the pending transaction is lost. The controller shares rst.
- busy = (state != IDLE).

Decomposition:
- Package mem_arb_pkg:
  - arb_state_t enum (IDLE, ISSUE, WAIT_DONE, RESP)
  - owner_t enum (OWN_I, OWN_D)
  - constant MEM_IDLE = 2'b00
  - read/write size-code constants (RD_B=1 … RD_D=6, WR_B=1 … WR_D=4)
- One sub-module, mem_arb_pick: combinational owner selection, plus the streak counter register.

Test Plan:
- D-only read: d_req, addr 0x8000_0010, d_rd_ctrl=6; controller busy for 4 cycles, returns 0x1122334455667788 -> d_gnt at cycle 0, mem_rd_ctrl=6 held until mem_state!=0, d_rvalid with rdata 0x1122334455667788, d_err=0.
- Simultaneous i_req/d_req held continuously, MAX_D_STREAK=4 -> grants in order D,D,D,D,I,D,D,D,D,I; no port ever gets two gnts without an intervening rvalid.
- D with wr_ctrl=4 and rd_ctrl=6, d_wdata 0xDEADBEEF_CAFEF00D -> mem_wr_ctrl=4, mem_rd_ctrl=0, mem_din matches; d_rvalid with d_rdata=0.
- Controller holds mem_state=0 forever, TIMEOUT=64 -> ctrl held for 64 cycles, then d_rvalid with d_err=1, mem ctrl 0 afterwards; the next request is served normally.
- d_req with both ctrls 0 -> d_gnt, then d_rvalid with err=1 on the next cycle; mem ctrl never asserted.
- rst asserted in WAIT_DONE -> all outputs 0 immediately, busy=0, no rvalid; a pending i_req is granted after rst falls.
